// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode constants and the
// 3-sample majority vote used by both the receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser plus a tick-enabled sample history that,
// together with the live synchronised value, forms the 3-tap majority vote.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic data_i,
    input  logic tick_i,
    output logic rx_s_o,
    output logic bit_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 2'b11;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            if (tick_i) begin
                hist_q <= {hist_q[0], sync2_q};
            end
        end
    end

    // On the deciding tick the third sample is the one being taken right now,
    // so the vote combines the two stored ticks with the live value.
    assign rx_s_o = sync2_q;
    assign bit_o  = majority3(hist_q[1], hist_q[0], sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver with majority voting, optional parity,
// 1 or 2 stop bits, frame/parity/break/overrun status and a valid/ready output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 timer_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    input  logic                 clr_err,
    output uart_state_e          dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic          PAR_SENSE   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 frame_end;
    logic                 cnt_wrap;

    logic                 rx_s;
    logic                 samp_bit;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_done_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 break_det_q;
    logic                 overrun_q;

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .reset  (reset),
        .data_i (data_in),
        .tick_i (timer_done),
        .rx_s_o (rx_s),
        .bit_o  (samp_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        frame_end = 1'b0;
        cnt_wrap  = (cnt_q == CNT_LAST);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            // Half a bit into the start bit: a line back high is a glitch.
            // Otherwise restart the counter so later wraps land on bit centres.
            ST_START: begin
                if (timer_done) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            n_d     = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (timer_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        shreg_d = {samp_bit, shreg_q[DATA_BITS-1:1]};
                        if (n_q == N_DATA_LAST) begin
                            n_d     = '0;
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end
                end
            end

            ST_PARITY: begin
                if (timer_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        perr_d  = (^shreg_q) ^ samp_bit ^ PAR_SENSE;
                        n_d     = '0;
                        state_d = ST_STOP;
                    end
                end
            end

            // Completing at the centre of the last stop bit leaves half a bit
            // of margin to catch a back-to-back start edge.
            ST_STOP: begin
                if (timer_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        if (!samp_bit) begin
                            ferr_d = 1'b1;
                        end
                        if (n_q == N_STOP_LAST) begin
                            frame_end = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output handshake: rx_valid/rx_data form a valid/ready channel. A frame is
    // transferred on any cycle where rx_valid & rx_ready; rx_valid then drops
    // unless a new frame completes in that same cycle. Data and per-frame flags
    // hold after transfer. A completion while an untaken frame is still
    // presented (rx_valid & !rx_ready) overwrites it and sets sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_done_q <= frame_end;
            if (frame_end) begin
                rx_data_q    <= shreg_q;
                parity_err_q <= perr_q;
                frame_err_q  <= ferr_d;
                break_det_q  <= (shreg_q == '0) & ferr_d;
                rx_valid_q   <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (frame_end && rx_valid_q && !rx_ready) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed scoreboard bench for uart_rx_param: an 8N1 instance and an 8E1
// instance share clock, reset and baud tick; monitors check every rx_done.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

  // clock / reset / baud tick
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic timer_done = 1'b0;
  int   tick_div = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div   <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
    timer_done <= (tick_div == TICK_DIV - 1);
  end

  // 8N1 instance
  logic        data_in = 1'b1;
  logic        rx_ready = 1'b1;
  logic        clr_err = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_done, parity_err, frame_err, break_det, overrun;
  uart_state_e dbg_state;

  uart_rx_param dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .timer_done (timer_done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .dbg_state  (dbg_state)
  );

  // 8E1 instance
  logic        data_in_p = 1'b1;
  logic        rx_ready_p = 1'b1;
  logic        clr_err_p = 1'b0;
  logic [7:0]  rx_data_p;
  logic        rx_valid_p, rx_done_p, parity_err_p, frame_err_p, break_det_p, overrun_p;
  uart_state_e dbg_state_p;

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in_p),
    .timer_done (timer_done),
    .rx_data    (rx_data_p),
    .rx_valid   (rx_valid_p),
    .rx_ready   (rx_ready_p),
    .rx_done    (rx_done_p),
    .parity_err (parity_err_p),
    .frame_err  (frame_err_p),
    .break_det  (break_det_p),
    .overrun    (overrun_p),
    .clr_err    (clr_err_p),
    .dbg_state  (dbg_state_p)
  );

  // scoreboard: {break_det, frame_err, parity_err, rx_data}
  logic [10:0] exp_q[$];
  logic [10:0] exp_p_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic prev_done = 1'b0;
  logic prev_done_p = 1'b0;

  always @(negedge clk) begin : mon_main
    logic [10:0] e;
    if (!reset && rx_done) begin
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got rx_data 0x%0h with no frame expected", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("frame_8n1", {21'd0, break_det, frame_err, parity_err, rx_data}, {21'd0, e});
      end
    end
    prev_done = rx_done;
  end

  always @(negedge clk) begin : mon_par
    logic [10:0] e;
    if (!reset && rx_done_p) begin
      check("done_pulse_width_p", {31'd0, prev_done_p}, 32'd0);
      if (exp_p_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done_p: got rx_data 0x%0h with no frame expected", rx_data_p);
      end else begin
        e = exp_p_q.pop_front();
        check("frame_8e1", {21'd0, break_det_p, frame_err_p, parity_err_p, rx_data_p}, {21'd0, e});
      end
    end
    prev_done_p = rx_done_p;
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (timer_done) k++;
    end
  endtask

  task automatic drive_level(input bit sel, input logic v, input int n);
    if (sel) data_in_p = v;
    else     data_in   = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par, input bit stop_ok);
    drive_level(sel, 1'b0, OS);
    for (int i = 0; i < 8; i++) drive_level(sel, d[i], OS);
    if (with_par) drive_level(sel, par, OS);
    if (stop_ok) begin
      drive_level(sel, 1'b1, OS);
    end else begin
      drive_level(sel, 1'b0, 10);
      drive_level(sel, 1'b1, OS - 10);
    end
    drive_level(sel, 1'b1, 2 * OS);
  endtask

  initial begin
    int budget;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
    check("rst_rx_data",    {24'd0, rx_data},    32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err},  32'd0);
    check("rst_break_det",  {31'd0, break_det},  32'd0);
    check("rst_overrun",    {31'd0, overrun},    32'd0);
    check("rst_rx_done",    {31'd0, rx_done},    32'd0);
    check("rst_state",      dbg_state,           ST_IDLE);
    check("rst_state_p",    dbg_state_p,         ST_IDLE);
    wait_ticks(2 * OS);

    // 8N1 0xA5, consumer ready
    exp_q.push_back({3'b000, 8'hA5});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_consumed_valid", {31'd0, rx_valid}, 32'd0);
    check("a5_data_held",      {24'd0, rx_data},  32'h0000_00A5);

    // even parity: 0x07 has odd weight, so a correct parity bit is 1
    exp_p_q.push_back({3'b001, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    check("par0_parity_err", {31'd0, parity_err_p}, 32'd1);
    exp_p_q.push_back({3'b000, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    check("par1_parity_err", {31'd0, parity_err_p}, 32'd0);

    // 3-tick low glitch on an idle line
    drive_level(1'b0, 1'b0, 3);
    drive_level(1'b0, 1'b1, 4);
    check("glitch_in_start", dbg_state, ST_START);
    wait_ticks(OS);
    check("glitch_back_idle", dbg_state, ST_IDLE);
    check("glitch_no_valid",  {31'd0, rx_valid},  32'd0);
    check("glitch_no_ferr",   {31'd0, frame_err}, 32'd0);

    // break: all-zero payload with stop bit low
    exp_q.push_back({3'b110, 8'h00});
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("break_frame_err", {31'd0, frame_err}, 32'd1);
    check("break_break_det", {31'd0, break_det}, 32'd1);
    check("break_state",     dbg_state,          ST_IDLE);

    // overrun: two frames with no consumer
    check("pre_overrun", {31'd0, overrun}, 32'd0);
    rx_ready = 1'b0;
    exp_q.push_back({3'b000, 8'h11});
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    check("ovr_first_no_overrun", {31'd0, overrun}, 32'd0);
    exp_q.push_back({3'b000, 8'h22});
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_rx_data",  {24'd0, rx_data},  32'h0000_0022);
    check("ovr_overrun",  {31'd0, overrun},  32'd1);
    check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_overrun",      {31'd0, overrun},  32'd0);
    check("clr_valid_intact", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("accept_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("accept_data_hold",  {24'd0, rx_data},  32'h0000_0022);

    // 0xFF with a single-tick low spike inside data bit 3
    exp_q.push_back({3'b000, 8'hFF});
    drive_level(1'b0, 1'b0, OS);
    drive_level(1'b0, 1'b1, 3 * OS + 7);
    drive_level(1'b0, 1'b0, 1);
    drive_level(1'b0, 1'b1, (OS - 8) + 4 * OS);
    drive_level(1'b0, 1'b1, OS);
    drive_level(1'b0, 1'b1, 2 * OS);
    check("spike_rx_data", {24'd0, rx_data}, 32'h0000_00FF);

    // reset in the middle of a frame
    drive_level(1'b0, 1'b0, OS);
    drive_level(1'b0, 1'b1, OS);
    drive_level(1'b0, 1'b0, OS);
    check("midframe_busy", dbg_state, ST_DATA);
    data_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_state",     dbg_state,          ST_IDLE);
    check("mrst_rx_data",   {24'd0, rx_data},   32'd0);
    check("mrst_rx_valid",  {31'd0, rx_valid},  32'd0);
    check("mrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mrst_rx_data_p", {24'd0, rx_data_p}, 32'd0);
    wait_ticks(2 * OS);
    check("mrst_no_done", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("post_rst_rx_data", {24'd0, rx_data}, 32'h0000_003C);

    // drain
    budget = 0;
    while ((exp_q.size() != 0 || exp_p_q.size() != 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("exp_q_drained",   exp_q.size(),   32'd0);
    check("exp_p_q_drained", exp_p_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
